// File: rtl/chess_clock_controller.sv
// Two-player chess clock: turn tracking, one-second prescaler, BCD countdown and timeout flag.
// Optional Fischer increment enabled by defining CHESS_CLOCK_INCREMENT_EN.
module chess_clock_controller #(
  parameter int CLOCK_FREQ    = 50000000,
  parameter int START_MINS    = 5,
  parameter int INCREMENT_SEC = 0
) (
  input  logic       clock,
  input  logic       globalReset,
  input  logic       playEnable,
  input  logic       timerEnable,
  input  logic       moveDone,
  output logic [3:0] whiteMins,
  output logic [3:0] whiteTensSec,
  output logic [3:0] whiteUnitsSec,
  output logic [3:0] blackMins,
  output logic [3:0] blackTensSec,
  output logic [3:0] blackUnitsSec,
  output logic       activePlayer,
  output logic       running,
  output logic       timeout,
  output logic       timeoutPlayer
);

  localparam int PRE_W = $clog2(CLOCK_FREQ);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLOCK_FREQ - 1);
  localparam logic [11:0] PRESET = {4'(START_MINS), 4'd0, 4'd0};

  typedef enum logic [2:0] {
    IDLE,
    WHITE_RUN,
    BLACK_RUN,
    PAUSED,
    TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic             saved_side_q, saved_side_d;
  logic [11:0]      white_time_q, white_time_d;
  logic [11:0]      black_time_q, black_time_d;
  logic             active_q, active_d;
  logic             running_q, running_d;
  logic             timeout_q, timeout_d;
  logic             timeout_player_q, timeout_player_d;

  logic             tick;
  logic             next_side;
  logic [11:0]      active_time;
  logic [11:0]      dec_time;

  // Times are packed {minutes, tens, units}; the decrement holds at 0:0:0.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [3:0] m, tn, u;
    m  = t[11:8];
    tn = t[7:4];
    u  = t[3:0];
    if (t == 12'h000) begin
      return t;
    end
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (tn != 4'd0) begin
        tn = tn - 4'd1;
      end else begin
        tn = 4'd5;
        m  = m - 4'd1;
      end
    end
    return {m, tn, u};
  endfunction

`ifdef CHESS_CLOCK_INCREMENT_EN
  logic [11:0] inc_time;

  function automatic logic [11:0] bcd_inc(input logic [11:0] t);
    logic [4:0] u_sum;
    logic [3:0] m, tn, u;
    logic       c_u, c_t;
    m     = t[11:8];
    tn    = t[7:4];
    u     = t[3:0];
    u_sum = {1'b0, u} + 5'(INCREMENT_SEC);
    c_u   = (u_sum > 5'd9);
    u     = c_u ? 4'(u_sum - 5'd10) : u_sum[3:0];
    tn    = tn + {3'b000, c_u};
    c_t   = (tn > 4'd5);
    if (c_t) begin
      tn = 4'd0;
    end
    if (c_t && (m == 4'd9)) begin
      return 12'h959;
    end
    m = m + {3'b000, c_t};
    return {m, tn, u};
  endfunction

  assign inc_time = bcd_inc(active_time);
`else
  logic unused_increment_cfg;
  assign unused_increment_cfg = (INCREMENT_SEC != 0);
`endif

  assign tick        = (prescaler_q == PRE_MAX);
  assign active_time = active_q ? black_time_q : white_time_q;
  assign dec_time    = bcd_dec(active_time);
  assign next_side   = moveDone ? ~saved_side_q : saved_side_q;

  always_comb begin
    state_d          = state_q;
    prescaler_d      = prescaler_q;
    saved_side_d     = saved_side_q;
    white_time_d     = white_time_q;
    black_time_d     = black_time_q;
    active_d         = active_q;
    timeout_d        = timeout_q;
    timeout_player_d = timeout_player_q;

    if (!playEnable) begin
      state_d          = IDLE;
      prescaler_d      = '0;
      saved_side_d     = 1'b0;
      white_time_d     = PRESET;
      black_time_d     = PRESET;
      active_d         = 1'b0;
      timeout_d        = 1'b0;
      timeout_player_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          white_time_d = PRESET;
          black_time_d = PRESET;
          if (timerEnable) begin
            state_d     = WHITE_RUN;
            prescaler_d = '0;
            active_d    = 1'b0;
          end
        end
        WHITE_RUN, BLACK_RUN: begin
          // A move wins over a coincident tick, which is simply dropped.
          if (moveDone) begin
            active_d    = ~active_q;
            state_d     = active_q ? WHITE_RUN : BLACK_RUN;
            prescaler_d = '0;
`ifdef CHESS_CLOCK_INCREMENT_EN
            if (active_q) begin
              black_time_d = inc_time;
            end else begin
              white_time_d = inc_time;
            end
`endif
          end else if (!timerEnable) begin
            state_d      = PAUSED;
            saved_side_d = active_q;
          end else if (tick) begin
            prescaler_d = '0;
            if (active_q) begin
              black_time_d = dec_time;
            end else begin
              white_time_d = dec_time;
            end
            if (dec_time == 12'h000) begin
              state_d          = TIMEOUT;
              timeout_d        = 1'b1;
              timeout_player_d = active_q;
            end
          end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
          end
        end
        PAUSED: begin
          if (moveDone) begin
            saved_side_d = ~saved_side_q;
            active_d     = ~active_q;
            prescaler_d  = '0;
          end
          if (timerEnable) begin
            state_d = next_side ? BLACK_RUN : WHITE_RUN;
          end
        end
        TIMEOUT: begin
          state_d = TIMEOUT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == WHITE_RUN) || (state_d == BLACK_RUN);
  end

  always_ff @(posedge clock) begin
    if (globalReset) begin
      state_q          <= IDLE;
      prescaler_q      <= '0;
      saved_side_q     <= 1'b0;
      white_time_q     <= PRESET;
      black_time_q     <= PRESET;
      active_q         <= 1'b0;
      running_q        <= 1'b0;
      timeout_q        <= 1'b0;
      timeout_player_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      prescaler_q      <= prescaler_d;
      saved_side_q     <= saved_side_d;
      white_time_q     <= white_time_d;
      black_time_q     <= black_time_d;
      active_q         <= active_d;
      running_q        <= running_d;
      timeout_q        <= timeout_d;
      timeout_player_q <= timeout_player_d;
    end
  end

  assign whiteMins     = white_time_q[11:8];
  assign whiteTensSec  = white_time_q[7:4];
  assign whiteUnitsSec = white_time_q[3:0];
  assign blackMins     = black_time_q[11:8];
  assign blackTensSec  = black_time_q[7:4];
  assign blackUnitsSec = black_time_q[3:0];
  assign activePlayer  = active_q;
  assign running       = running_q;
  assign timeout       = timeout_q;
  assign timeoutPlayer = timeout_player_q;

endmodule
